// File: rtl/cacode_correlator.sv
// rtl/cacode_correlator.sv - GPS C/A code despreader with serial code-phase search
//
// Correlates hard-decision received chips against a locally generated 1023-chip
// Gold code, integrates one code period at a time and slips the local code by one
// chip after every period whose |sum| stays below THRESH.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   start, abort        begin a search (prn_num latched) / return to IDLE
//   prn_num[5:0]        satellite PRN 1..37
//   rx_chip, rx_valid   received chip stream, one chip per valid cycle
//   corr_out[10:0]      signed period sum, with corr_valid pulse
//   locked, fail, busy  status decoded from the search state
//   code_phase[9:0]     chips slipped so far, updated at each period end
module cacode_correlator #(
    parameter int THRESH     = 512,
    parameter int MAX_PHASES = 1023
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        abort,
    input  logic [5:0]  prn_num,
    input  logic        rx_chip,
    input  logic        rx_valid,
    output logic [10:0] corr_out,
    output logic        corr_valid,
    output logic        locked,
    output logic [9:0]  code_phase,
    output logic        fail,
    output logic        busy
);

    typedef enum logic [2:0] {S_IDLE, S_ACCUM, S_SLIP, S_LOCKED, S_FAIL} state_t;

    state_t             state, state_next;
    logic [10:1]        g1, g2;
    logic [3:0]         tap_a, tap_b;
    logic signed [10:0] acc;
    logic [9:0]         chip_cnt;
    logic [9:0]         phase;

    logic [7:0]         sel;
    logic               prn_ok;
    logic               local_chip;
    logic signed [10:0] sum;
    logic [10:0]        abs_sum;
    logic               hit, last_phase;
    logic               can_start, start_go, chip_step, period_end;

    // G2 phase-selector tap pairs, packed as {tap_a, tap_b}; 4'ha means tap 10.
    always_comb begin
        sel    = 8'h12;
        prn_ok = 1'b1;
        case (prn_num)
            6'd1:  sel = 8'h26;  6'd2:  sel = 8'h37;  6'd3:  sel = 8'h48;  6'd4:  sel = 8'h59;
            6'd5:  sel = 8'h19;  6'd6:  sel = 8'h2a;  6'd7:  sel = 8'h18;  6'd8:  sel = 8'h29;
            6'd9:  sel = 8'h3a;  6'd10: sel = 8'h23;  6'd11: sel = 8'h34;  6'd12: sel = 8'h56;
            6'd13: sel = 8'h67;  6'd14: sel = 8'h78;  6'd15: sel = 8'h89;  6'd16: sel = 8'h9a;
            6'd17: sel = 8'h14;  6'd18: sel = 8'h25;  6'd19: sel = 8'h36;  6'd20: sel = 8'h47;
            6'd21: sel = 8'h58;  6'd22: sel = 8'h69;  6'd23: sel = 8'h13;  6'd24: sel = 8'h46;
            6'd25: sel = 8'h57;  6'd26: sel = 8'h68;  6'd27: sel = 8'h79;  6'd28: sel = 8'h8a;
            6'd29: sel = 8'h16;  6'd30: sel = 8'h27;  6'd31: sel = 8'h38;  6'd32: sel = 8'h49;
            6'd33: sel = 8'h5a;  6'd34: sel = 8'h4a;  6'd35: sel = 8'h17;  6'd36: sel = 8'h28;
            6'd37: sel = 8'h4a;
            default: prn_ok = 1'b0;
        endcase
    end

    assign local_chip = g1[10] ^ g2[tap_a] ^ g2[tap_b];
    assign sum        = (rx_chip == local_chip) ? acc + 11'sd1 : acc - 11'sd1;
    assign abs_sum    = sum[10] ? 11'(-sum) : 11'(sum);
    assign hit        = abs_sum >= 11'(THRESH);
    assign last_phase = phase == 10'(MAX_PHASES - 1);

    assign can_start  = (state == S_IDLE) || (state == S_LOCKED) || (state == S_FAIL);
    assign start_go   = start && can_start;
    assign chip_step  = rx_valid && ((state == S_ACCUM) || (state == S_LOCKED));
    assign period_end = chip_step && (chip_cnt == 10'd1022);

    assign locked = state == S_LOCKED;
    assign fail   = state == S_FAIL;
    assign busy   = (state == S_ACCUM) || (state == S_SLIP);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (abort) begin
            state_next = S_IDLE;
        end else if (start_go) begin
            state_next = prn_ok ? S_ACCUM : S_FAIL;
        end else if (period_end) begin
            if (hit)             state_next = S_LOCKED;
            else if (last_phase) state_next = S_FAIL;
            else                 state_next = S_SLIP;
        end else if (state == S_SLIP && rx_valid) begin
            state_next = S_ACCUM;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            g1         <= '1;
            g2         <= '1;
            tap_a      <= 4'd1;
            tap_b      <= 4'd2;
            acc        <= '0;
            chip_cnt   <= '0;
            phase      <= '0;
            corr_out   <= '0;
            corr_valid <= 1'b0;
            code_phase <= '0;
        end else begin
            corr_valid <= 1'b0;
            if (abort) begin
                g1         <= '1;
                g2         <= '1;
                acc        <= '0;
                chip_cnt   <= '0;
                phase      <= '0;
                corr_out   <= '0;
                code_phase <= '0;
            end else if (start_go) begin
                if (prn_ok) begin
                    tap_a      <= sel[7:4];
                    tap_b      <= sel[3:0];
                    g1         <= '1;
                    g2         <= '1;
                    acc        <= '0;
                    chip_cnt   <= '0;
                    phase      <= '0;
                    code_phase <= '0;
                end
            end else if (chip_step) begin
                g1 <= {g1[9:1], g1[3] ^ g1[10]};
                g2 <= {g2[9:1], g2[2] ^ g2[3] ^ g2[6] ^ g2[8] ^ g2[9] ^ g2[10]};
                if (period_end) begin
                    // LFSRs wrap back to all-ones here, so the next period restarts the code.
                    acc        <= '0;
                    chip_cnt   <= '0;
                    corr_out   <= sum;
                    corr_valid <= 1'b1;
                    code_phase <= phase;
                end else begin
                    acc      <= sum;
                    chip_cnt <= chip_cnt + 10'd1;
                end
            end else if (state == S_SLIP && rx_valid) begin
                // Dropping one received chip while the code is held delays the local code by one chip.
                phase <= phase + 10'd1;
            end
        end
    end

endmodule

// File: tb/tb_cacode_correlator.sv
// tb/tb_cacode_correlator.sv - self-checking bench for cacode_correlator
module tb_cacode_correlator;

    localparam int TH = 512;
    localparam int MP = 16;
    localparam int M_IDLE = 0, M_SRCH = 1, M_SLIP = 2, M_LOCK = 3, M_FAIL = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [5:0]  prn_num = 6'd0;
    logic        rx_chip = 1'b0;
    logic        rx_valid = 1'b0;
    logic [10:0] corr_out;
    logic        corr_valid;
    logic        locked;
    logic [9:0]  code_phase;
    logic        fail;
    logic        busy;

    always #5 clk = ~clk;

    cacode_correlator #(.THRESH(TH), .MAX_PHASES(MP)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .prn_num(prn_num),
        .rx_chip(rx_chip), .rx_valid(rx_valid), .corr_out(corr_out),
        .corr_valid(corr_valid), .locked(locked), .code_phase(code_phase),
        .fail(fail), .busy(busy)
    );

    bit code_tab [38][1023];
    int n_checks = 0;
    int n_pass = 0;
    int n_printed = 0;
    int sums_q[$];

    // Reference model: code index / match counting over whole periods
    int m_mode = M_IDLE, m_prn = 1, m_idx = 0, m_n = 0, m_sum = 0, m_phase = 0;
    int e_corr = 0, e_phase = 0;
    bit e_valid = 1'b0;

    function automatic int iabs(input int x);
        return (x < 0) ? -x : x;
    endfunction

    function automatic int tap_pair(input int p);
        case (p)
            1: return 'h26;  2: return 'h37;  3: return 'h48;  4: return 'h59;  5: return 'h19;
            6: return 'h2a;  7: return 'h18;  8: return 'h29;  9: return 'h3a;  10: return 'h23;
            11: return 'h34; 12: return 'h56; 13: return 'h67; 14: return 'h78; 15: return 'h89;
            16: return 'h9a; 17: return 'h14; 18: return 'h25; 19: return 'h36; 20: return 'h47;
            21: return 'h58; 22: return 'h69; 23: return 'h13; 24: return 'h46; 25: return 'h57;
            26: return 'h68; 27: return 'h79; 28: return 'h8a; 29: return 'h16; 30: return 'h27;
            31: return 'h38; 32: return 'h49; 33: return 'h5a; 34: return 'h4a; 35: return 'h17;
            36: return 'h28; default: return 'h4a;
        endcase
    endfunction

    task automatic gen_codes();
        for (int p = 1; p <= 37; p++) begin
            logic [10:1] g1;
            logic [10:1] g2;
            int a;
            int b;
            a  = tap_pair(p) / 16;
            b  = tap_pair(p) % 16;
            g1 = '1;
            g2 = '1;
            for (int i = 0; i < 1023; i++) begin
                code_tab[p][i] = g1[10] ^ g2[a] ^ g2[b];
                g1 = {g1[9:1], g1[3] ^ g1[10]};
                g2 = {g2[9:1], g2[2] ^ g2[3] ^ g2[6] ^ g2[8] ^ g2[9] ^ g2[10]};
            end
        end
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst || abort) begin
            m_mode = M_IDLE; m_idx = 0; m_n = 0; m_sum = 0; m_phase = 0;
            e_corr = 0; e_phase = 0; e_valid = 1'b0;
        end else begin
            e_valid = 1'b0;
            if (start && (m_mode == M_IDLE || m_mode == M_LOCK || m_mode == M_FAIL)) begin
                if (prn_num >= 1 && prn_num <= 37) begin
                    m_mode = M_SRCH; m_prn = int'(prn_num);
                    m_idx = 0; m_n = 0; m_sum = 0; m_phase = 0; e_phase = 0;
                end else begin
                    m_mode = M_FAIL;
                end
            end else if (rx_valid && (m_mode == M_SRCH || m_mode == M_LOCK)) begin
                m_sum += (rx_chip == code_tab[m_prn][m_idx]) ? 1 : -1;
                m_idx = (m_idx + 1) % 1023;
                m_n++;
                if (m_n == 1023) begin
                    e_valid = 1'b1; e_corr = m_sum; e_phase = m_phase;
                    if (iabs(m_sum) >= TH)   m_mode = M_LOCK;
                    else if (m_phase == MP - 1) m_mode = M_FAIL;
                    else                     m_mode = M_SLIP;
                    m_n = 0; m_sum = 0;
                end
            end else if (rx_valid && m_mode == M_SLIP) begin
                m_phase++;
                m_mode = M_SRCH;
            end
        end
    end

    always @(negedge clk) begin
        n_checks++;
        if (int'($signed(corr_out)) != e_corr || corr_valid !== e_valid ||
            locked !== (m_mode == M_LOCK) || fail !== (m_mode == M_FAIL) ||
            busy !== (m_mode == M_SRCH || m_mode == M_SLIP) || code_phase !== 10'(e_phase)) begin
            if (n_printed < 20)
                $display("FAIL cycle_model t=%0t: dut out=%0d v=%0b lk=%0b fl=%0b bz=%0b ph=%0d, model out=%0d v=%0b mode=%0d ph=%0d",
                         $time, $signed(corr_out), corr_valid, locked, fail, busy, code_phase,
                         e_corr, e_valid, m_mode, e_phase);
            n_printed++;
        end else begin
            n_pass++;
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic step(input bit v, input bit c);
        rx_valid = v;
        rx_chip  = c;
        @(posedge clk);
        #1;
        start    = 1'b0;
        abort    = 1'b0;
        rx_valid = 1'b0;
    endtask

    task automatic pulse_start(input int p);
        prn_num = 6'(p);
        start   = 1'b1;
        step(1'b0, 1'b0);
    endtask

    // Streams chips of PRN prn beginning at code index offset until n_pulses period sums seen.
    task automatic run_stream(input int prn, input int offset, input bit inv, input bit rnd,
                              input bit gaps, input int n_pulses, output int got);
        int  j;
        bit  c;
        j   = 0;
        got = 0;
        sums_q.delete();
        while (got < n_pulses && j < 1100 * n_pulses) begin
            if (gaps && $urandom_range(0, 7) == 0)
                repeat ($urandom_range(1, 7)) step(1'b0, 1'($urandom_range(0, 1)));
            c = rnd ? 1'($urandom_range(0, 1)) : (code_tab[prn][(offset + j) % 1023] ^ inv);
            step(1'b1, c);
            j++;
            if (corr_valid) begin
                sums_q.push_back(int'($signed(corr_out)));
                got++;
            end
        end
    endtask

    initial begin
        int got;
        int v;
        int bad;
        gen_codes();

        v = 0;
        for (int i = 0; i < 10; i++) v = v * 2 + int'(code_tab[1][i]);
        check("prn1_first10_chips", v, 'b1100100000);
        v = 0;
        for (int i = 0; i < 1023; i++) v += int'(code_tab[1][i]);
        check("prn1_ones", v, 512);
        v = 0;
        for (int i = 0; i < 1023; i++) v += int'(code_tab[7][i]);
        check("prn7_ones", v, 512);

        repeat (2) step(1'b0, 1'b0);
        check("rst_corr_out", int'(corr_out), 0);
        check("rst_corr_valid", int'(corr_valid), 0);
        check("rst_locked", int'(locked), 0);
        check("rst_fail", int'(fail), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_code_phase", int'(code_phase), 0);
        rst = 1'b0;
        step(1'b0, 1'b0);

        // aligned PRN 1
        pulse_start(1);
        check("t1_busy_after_start", int'(busy), 1);
        run_stream(1, 0, 1'b0, 1'b0, 1'b0, 1, got);
        check("t1_pulses", got, 1);
        check("t1_sum", int'($signed(corr_out)), 1023);
        check("t1_locked", int'(locked), 1);
        check("t1_code_phase", int'(code_phase), 0);
        check("t1_busy", int'(busy), 0);
        step(1'b0, 1'b0);
        check("t1_valid_one_cycle", int'(corr_valid), 0);

        // inverted polarity
        pulse_start(1);
        run_stream(1, 0, 1'b1, 1'b0, 1'b0, 1, got);
        check("t2_pulses", got, 1);
        check("t2_raw", int'(corr_out), 'h401);
        check("t2_locked", int'(locked), 1);

        // PRN 7 offset 1018: five slips then lock
        pulse_start(7);
        run_stream(7, 1018, 1'b0, 1'b0, 1'b0, 6, got);
        check("t3_pulses", got, 6);
        bad = 0;
        for (int i = 0; i < 5 && i < sums_q.size(); i++) if (iabs(sums_q[i]) > 65) bad++;
        check("t3_small_sums", bad, 0);
        check("t3_sum6", (sums_q.size() == 6) ? sums_q[5] : 0, 1023);
        check("t3_locked", int'(locked), 1);
        check("t3_code_phase", int'(code_phase), 5);

        // lock, then random chips with gaps
        pulse_start(1);
        run_stream(1, 0, 1'b0, 1'b0, 1'b0, 1, got);
        check("t5_locked_first", int'(locked), 1);
        run_stream(1, 0, 1'b0, 1'b1, 1'b1, 1, got);
        check("t5_pulses", got, 1);
        check("t5_low_sum", (got == 1 && iabs(sums_q[0]) < TH) ? 1 : 0, 1);
        check("t5_lock_dropped", int'(locked), 0);
        check("t5_busy", int'(busy), 1);
        abort = 1'b1;
        step(1'b0, 1'b0);
        check("t5_abort_idle", int'(busy), 0);
        pulse_start(1);
        run_stream(1, 0, 1'b0, 1'b0, 1'b1, 1, got);
        check("t5_gapped_sum", int'($signed(corr_out)), 1023);
        check("t5_gapped_locked", int'(locked), 1);

        // wrong PRN, search exhausts MAX_PHASES
        pulse_start(5);
        run_stream(3, 0, 1'b0, 1'b0, 1'b0, 16, got);
        check("t4_pulses", got, 16);
        bad = 0;
        foreach (sums_q[i]) if (iabs(sums_q[i]) > 65) bad++;
        check("t4_small_sums", bad, 0);
        check("t4_fail", int'(fail), 1);
        check("t4_locked", int'(locked), 0);
        repeat (3) step(1'b1, 1'b0);
        check("t4_fail_holds", int'(fail), 1);
        pulse_start(0);
        check("t4_prn0_fail", int'(fail), 1);

        // async reset mid-accumulation, start while busy ignored
        pulse_start(1);
        for (int i = 0; i < 500; i++) step(1'b1, code_tab[1][i]);
        prn_num = 6'd7;
        start   = 1'b1;
        step(1'b1, code_tab[1][500]);
        for (int i = 501; i < 600; i++) step(1'b1, code_tab[1][i]);
        check("t6_busy_before_rst", int'(busy), 1);
        #2 rst = 1'b1;
        #1;
        check("t6_rst_corr_out", int'(corr_out), 0);
        check("t6_rst_busy", int'(busy), 0);
        check("t6_rst_locked", int'(locked), 0);
        check("t6_rst_fail", int'(fail), 0);
        check("t6_rst_code_phase", int'(code_phase), 0);
        @(negedge clk);
        rst = 1'b0;
        step(1'b0, 1'b0);

        // abort in SLIP
        pulse_start(7);
        run_stream(7, 1018, 1'b0, 1'b0, 1'b0, 1, got);
        check("t6_slip_busy", int'(busy), 1);
        abort = 1'b1;
        step(1'b1, 1'b0);
        check("t6_abort_busy", int'(busy), 0);
        check("t6_abort_valid", int'(corr_valid), 0);
        check("t6_abort_corr_out", int'(corr_out), 0);
        pulse_start(38);
        check("t6_prn38_fail", int'(fail), 1);
        pulse_start(1);
        run_stream(1, 0, 1'b0, 1'b0, 1'b0, 1, got);
        check("t6_restart_sum", int'($signed(corr_out)), 1023);
        check("t6_restart_phase", int'(code_phase), 0);
        check("t6_restart_locked", int'(locked), 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
